// File: rtl/ddr_pattern_tester_pkg.sv
// Shared types and constants for the DDR pattern tester: FSM states,
// LFSR taps, pattern-mode selects and the default handshake timeout.
package ddr_pattern_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_REQ  = 3'd1,
        ST_W_WAIT = 3'd2,
        ST_R_REQ  = 3'd3,
        ST_R_WAIT = 3'd4,
        ST_CHECK  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned PAT_ADDR = 0;
    localparam int unsigned PAT_LFSR = 1;

    localparam int unsigned TIMEOUT_DEFAULT = 4096;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ddr_pat_lfsr16.sv
// 16-bit Galois LFSR pattern source with synchronous seed load.
// Latency: new state one cycle after load/step.
// Backpressure: none; advances only when step is asserted.
module ddr_pat_lfsr16
    import ddr_pattern_tester_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= seed;
        end else if (step) begin
            lfsr <= lfsr16_next(lfsr);
        end
    end

endmodule

// File: rtl/ddr_pattern_tester.sv
// Self-running write-all/read-all memory tester for the wrapper request bus.
// Latency: one request per wrapper handshake; results are registered.
// Backpressure: holds each request until ready drops, then waits for ready to return.
module ddr_pattern_tester
    import ddr_pattern_tester_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] ADDR_START = '0,
    parameter logic [ADDR_W-1:0] ADDR_END   = 28'hFFFFFFF,
    parameter int unsigned       PATTERN    = PAT_ADDR,
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
    parameter int unsigned       TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    output logic [31:0]       o_Addr,
    output logic              o_CS,
    output logic              o_L,
    output logic              o_U,
    output logic              o_WE,
    output logic [15:0]       o_WR,
    input  logic [15:0]       i_RD,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_phase,
    output logic [15:0]       o_pass_cnt,
    output logic [31:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [15:0]       o_first_err_exp,
    output logic [15:0]       o_first_err_got,
    output logic              o_timeout
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              invert;
    logic              stop_pend;
    logic [15:0]       rd_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [15:0]       lfsr_q;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              at_end;
    logic              go;
    logic              in_req;
    logic              in_wait;
    logic              tmo_hit;
    logic [15:0]       pat;

    assign at_end  = (addr == ADDR_END);
    assign go      = i_start && i_ready && !o_timeout;
    assign in_req  = (state == ST_W_REQ) || (state == ST_R_REQ);
    assign in_wait = (state == ST_W_WAIT) || (state == ST_R_WAIT);
    assign tmo_hit = ((in_req && i_ready) || (in_wait && !i_ready)) && (tmo_cnt == TMO_LAST);
    assign pat     = ((PATTERN == PAT_LFSR) ? lfsr_q : 16'(addr)) ^ {16{invert}};

    // The LFSR is re-seeded at every phase start so reads replay the write sequence
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE:   lfsr_load = go;
            ST_W_WAIT: begin
                lfsr_load = i_ready && at_end;
                lfsr_step = i_ready && !at_end;
            end
            ST_CHECK:  begin
                lfsr_load = at_end;
                lfsr_step = !at_end;
            end
            default:   ;
        endcase
    end

    ddr_pat_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (i_rst),
        .load (lfsr_load),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .lfsr (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            addr             <= ADDR_START;
            invert           <= 1'b0;
            stop_pend        <= 1'b0;
            rd_q             <= '0;
            tmo_cnt          <= '0;
            o_Addr           <= '0;
            o_CS             <= 1'b0;
            o_L              <= 1'b0;
            o_U              <= 1'b0;
            o_WE             <= 1'b0;
            o_WR             <= '0;
            o_busy           <= 1'b0;
            o_phase          <= 1'b0;
            o_pass_cnt       <= '0;
            o_err_cnt        <= '0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_got  <= '0;
            o_timeout        <= 1'b0;
        end else if (tmo_hit) begin
            state     <= ST_HALT;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            o_CS      <= 1'b0;
            o_L       <= 1'b0;
            o_U       <= 1'b0;
            o_WE      <= 1'b0;
            o_WR      <= '0;
            o_Addr    <= '0;
        end else begin
            if (i_stop && state != ST_IDLE) begin
                stop_pend <= 1'b1;
            end
            if (in_req || in_wait) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    if (go) begin
                        addr    <= ADDR_START;
                        tmo_cnt <= '0;
                        o_busy  <= 1'b1;
                        o_phase <= 1'b0;
                        state   <= ST_W_REQ;
                    end
                end

                ST_W_REQ, ST_R_REQ: begin
                    o_CS   <= 1'b1;
                    o_L    <= 1'b1;
                    o_U    <= 1'b1;
                    o_WE   <= (state == ST_W_REQ);
                    o_Addr <= 32'(addr);
                    o_WR   <= (state == ST_W_REQ) ? pat : 16'h0000;
                    if (!i_ready) begin
                        tmo_cnt <= '0;
                        state   <= (state == ST_W_REQ) ? ST_W_WAIT : ST_R_WAIT;
                    end
                end

                ST_W_WAIT: begin
                    o_CS   <= 1'b0;
                    o_L    <= 1'b0;
                    o_U    <= 1'b0;
                    o_WE   <= 1'b0;
                    o_WR   <= '0;
                    o_Addr <= '0;
                    if (i_ready) begin
                        tmo_cnt <= '0;
                        if (at_end) begin
                            addr    <= ADDR_START;
                            o_phase <= 1'b1;
                            state   <= ST_R_REQ;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ST_W_REQ;
                        end
                    end
                end

                ST_R_WAIT: begin
                    o_CS   <= 1'b0;
                    o_L    <= 1'b0;
                    o_U    <= 1'b0;
                    o_WE   <= 1'b0;
                    o_WR   <= '0;
                    o_Addr <= '0;
                    if (i_ready) begin
                        rd_q    <= i_RD;
                        tmo_cnt <= '0;
                        state   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    tmo_cnt <= '0;
                    if (rd_q != pat) begin
                        if (o_err_cnt != '1) begin
                            o_err_cnt <= o_err_cnt + 1'b1;
                        end
                        // Only the very first mismatch since reset is kept
                        if (o_err_cnt == '0) begin
                            o_first_err_addr <= addr;
                            o_first_err_exp  <= pat;
                            o_first_err_got  <= rd_q;
                        end
                    end
                    if (at_end) begin
                        addr       <= ADDR_START;
                        o_pass_cnt <= o_pass_cnt + 1'b1;
                        invert     <= ~invert;
                        o_phase    <= 1'b0;
                        if (i_start && !stop_pend && !i_stop) begin
                            state <= ST_W_REQ;
                        end else begin
                            stop_pend <= 1'b0;
                            o_busy    <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_R_REQ;
                    end
                end

                ST_HALT: ;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ddr_pattern_tester.md
Name: ddr_pattern_tester

Overview:
- Self-running memory test master that drives the SRAM-like request interface of sdram_ddr_wrapper (wrap_Addr/CS/L/U/WE/WR/RD/ready).
- Sits directly upstream of the wrapper.
- Writes a full address range, then reads the whole range back and verifies it. Addresses are only revisited after the full range has been written, so address aliasing is detected.
- Reports pass count, a saturating error count, first-error capture and handshake timeouts for LEDs and the ILA.

Parameters:
- ADDR_W, 28, width of the word address driven on o_Addr[ADDR_W-1:0]; the upper bits of the 32-bit bus are tied to 0.
- ADDR_START, 0, first word address tested.
- ADDR_END, 28'hFFFFFFF, last word address tested, inclusive. Must be >= ADDR_START.
- PATTERN, 0, data pattern select: 0 = address-based, 1 = 16-bit LFSR.
- LFSR_SEED, 16'hACE1, LFSR seed. Must be non-zero.
- TIMEOUT, 4096, maximum cycles allowed for each handshake edge.

Ports:
- clk  in  1  ui_clk domain of the wrapper.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  level; starts or keeps a run going.
- i_stop  in  1  pulse; stop at the next pass boundary.
- o_Addr  out  32  request address.
- o_CS  out  1  chip select.
- o_L  out  1  low byte enable.
- o_U  out  1  high byte enable.
- o_WE  out  1  write enable.
- o_WR  out  16  write data.
- i_RD  in  16  read data.
- i_ready  in  1  wrapper ready; low means busy.
- o_busy  out  1  tester active.
- o_phase  out  1  0 = write phase, 1 = read phase.
- o_pass_cnt  out  16  number of completed write+read passes; wraps.
- o_err_cnt  out  32  number of mismatches; saturates at all-ones.
- o_first_err_addr  out  ADDR_W  address of the first mismatch.
- o_first_err_exp  out  16  expected data at the first mismatch.
- o_first_err_got  out  16  read data at the first mismatch.
- o_timeout  out  1  sticky handshake timeout flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - Address counter = ADDR_START.
  - Invert flag = 0.
  - LFSR = LFSR_SEED.
- States: IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, CHECK, HALT.
- IDLE:
  - Leave for W_REQ when i_start=1, i_ready=1 and o_timeout=0.
  - On leaving, reload the address with ADDR_START and the LFSR with LFSR_SEED.
- W_REQ / R_REQ:
  - Drive CS=1, L=U=1, Addr = {0, addr}, and WE=1 (write) or WE=0 (read).
  - WR = pat (write only). Hold these values until i_ready is sampled 0, then go to *_WAIT.
- *_WAIT:
  - Deassert CS/L/U/WE the cycle after entry. Zero WR and Addr at the same time.
  - Wait for i_ready=1.
  - W_WAIT then advances the address, or switches phase.
  - R_WAIT goes to CHECK, registering i_RD in the same cycle that i_ready=1 is seen.
- CHECK (1 cycle):
  - Compare the registered i_RD with pat.
  - On mismatch, o_err_cnt increments (saturating). If o_err_cnt was 0, capture addr, exp and got; these captures are never overwritten until reset.
  - Then advance the address, or end the pass.
- Pattern:
  - PATTERN=0: pat = addr[15:0] XOR {16{invert}}.
  - PATTERN=1: pat = LFSR XOR {16{invert}}. The LFSR uses x^16+x^14+x^13+x^11+1 and steps once per address advance. It is reloaded to LFSR_SEED at the start of every phase, so the read phase regenerates the write sequence.
- Address at ADDR_END:
  - In the write phase: switch to the read phase, set o_phase=1, reload ADDR_START and the LFSR.
  - In the read phase: o_pass_cnt+1, toggle invert, set o_phase=0, reload.
  - Then W_REQ if i_start=1 and no stop is pending, otherwise IDLE.
- Stop:
  - i_stop sets a pending flag. The run continues until the pass boundary; the flag is cleared on entering IDLE.
  - Deasserting i_start mid-pass also takes effect only at the pass boundary.
- Timeout:
  - A counter reloads on every state entry and counts in *_REQ (waiting for ready=0) and *_WAIT (waiting for ready=1).
  - On reaching TIMEOUT: set o_timeout, deassert all request outputs, go to HALT.
  - HALT is left only by i_rst.
- Range:
  - ADDR_START == ADDR_END is a 1-word pass.
  - The address increment never exceeds ADDR_END; there is no wrap beyond the range.
- Reset mid-transaction:
  - Outputs are 0 on the cycle after i_rst is sampled.
  - The wrapper is expected to be reset by the same source.
- o_busy = 1 in every state except IDLE and HALT.

Decomposition:
- Shared package:
  - State encoding localparams.
  - LFSR polynomial/tap constant.
  - Pattern-mode constants.
  - Default TIMEOUT.
- One natural sub-module: ddr_pat_lfsr16, a 16-bit Galois LFSR with load, seed and step inputs.
- All other logic lives in the top FSM.

Test Plan:
- Bench wrapper model with ready-drop delay 2 and rise delay 5, ADDR_START=0, ADDR_END=7, PATTERN=0, i_start=1 → 8 writes with WR=0..7, then 8 reads; o_err_cnt=0, o_pass_cnt=1. The second pass writes 16'hFFFF..16'hFFF8.
- Model corrupts a read at addr 5 (returns 16'h0000) → o_err_cnt=1, first_err_addr=5, exp=16'h0005, got=16'h0000. A second corruption at addr 6 raises o_err_cnt to 2 and leaves the capture unchanged.
- PATTERN=1, ADDR_END=3 → write data = seed and the next 3 LFSR states; read phase expects the identical sequence and reports 0 errors.
- Model never drops ready, TIMEOUT=16 → o_timeout=1 within 17 cycles of CS; CS=0; state HALT; i_start ignored until i_rst.
- i_stop pulsed mid read phase → run completes the pass: o_pass_cnt increments by 1, then o_busy=0 and CS stays 0.
- i_rst asserted while o_CS=1 → the next cycle shows all outputs 0 and o_pass_cnt=0.
